// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, qualifies lock and gates the system reset
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 50000,
  parameter int GLITCH_CYCLES = 4,
  parameter int CNT_W         = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [7:0] lock_lost_cnt,
  output logic       timeout
);
  localparam logic [1:0] PRST      = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] STABLE    = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // the WAIT_LOCK sample that saw lock counts as the first stable cycle
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES > 1 ? STABLE_CYCLES - 2 : 0);
  localparam bit STB_SKIP = STABLE_CYCLES < 2;
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  localparam logic [GW-1:0] GLT_LAST = GW'(GLITCH_CYCLES - 1);

  logic             r_meta;
  logic             r_lk_s;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [GW-1:0]    r_glitch;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic [7:0]       r_lost;
  logic             r_timeout;
  logic [1:0]       w_nxt;
  logic             w_tmo;
  logic             w_loss;

  assign pll_rst       = r_pll_rst;
  assign sys_rst_n     = r_sys_rst_n;
  assign lock_lost_cnt = r_lost;
  assign timeout       = r_timeout;

  // two-flop synchronizer for the asynchronous lock indicator
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_lk_s <= 1'b0;
    end else begin
      r_meta <= locked;
      r_lk_s <= r_meta;
    end

  // next state; lock beats a coincident timeout, loss fires on the last tolerated low sample
  always_comb begin
    w_tmo  = 1'b0;
    w_loss = 1'b0;
    w_nxt  = r_state;
    case (r_state)
      PRST: w_nxt = (r_cnt == RST_LAST) ? WAIT_LOCK : PRST;
      WAIT_LOCK: begin
        w_tmo = !r_lk_s && r_cnt == TMO_LAST;
        w_nxt = r_lk_s ? (STB_SKIP ? RUN : STABLE) : w_tmo ? PRST : WAIT_LOCK;
      end
      STABLE: w_nxt = !r_lk_s ? WAIT_LOCK : (r_cnt == STB_LAST) ? RUN : STABLE;
      default: begin
        w_loss = !r_lk_s && r_glitch == GLT_LAST;
        w_nxt  = w_loss ? PRST : RUN;
      end
    endcase
  end

  // state, shared counter, glitch filter and registered outputs
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= PRST;
      r_cnt       <= '0;
      r_glitch    <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_lost      <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_cnt       <= (w_nxt != r_state) ? '0 : (r_state == RUN) ? r_cnt : r_cnt + 1'b1;
      r_glitch    <= (r_state == RUN && !r_lk_s && !w_loss) ? r_glitch + 1'b1 : '0;
      r_pll_rst   <= w_nxt == PRST;
      r_sys_rst_n <= w_nxt == RUN;
      r_lost      <= (w_loss && r_lost != 8'hFF) ? r_lost + 8'd1 : r_lost;
      r_timeout   <= r_timeout | w_tmo;
    end
endmodule
